pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and instruction-fetch stage of the processor. Holds the PC, issues fetch requests to instruction memory over a req/ready handshake, and presents each fetched instruction with its PC to decode. It consumes the taken/not-taken output of the branch-decision block and a jump request, and redirects the PC to the computed target.

## Interface
- `ADDR_WIDTH`, 32, PC/address width in bits (≥ 8)
- `INSTR_WIDTH`, 32, instruction width
- `RESET_PC`, 0, PC loaded on reset; bits [1:0] must be 0
- `clock`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `branch_taken`  in  1  taken decision from the branch-decision block; sampled every cycle
- `branch_base`  in  ADDR_WIDTH  PC of the branch instruction
- `branch_offset`  in  ADDR_WIDTH  signed word offset, already sign-extended
- `jump`  in  1  unconditional redirect request
- `jump_target`  in  ADDR_WIDTH  absolute jump address; bits [1:0] ignored
- `stall`  in  1  decode cannot accept the presented instruction
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_WIDTH  fetch address (= PC)
- `imem_ready`  in  1  memory accepts and returns data this cycle
- `imem_rdata`  in  INSTR_WIDTH  instruction data, valid when `imem_req && imem_ready`
- `instr_valid`  out  1  `instr`/`instr_pc` valid
- `instr`  out  INSTR_WIDTH  fetched instruction
- `instr_pc`  out  ADDR_WIDTH  address of `instr`

## Operation
- States: START, FETCH, HOLD.
- Reset (async, `reset_n` = 0): state START; PC = `RESET_PC`; `imem_req` = 0; `instr_valid` = 0; `instr` = 0; `instr_pc` = `RESET_PC`. `imem_addr` always equals PC.
- START: `imem_req` = 0; next clock → FETCH. START is entered only from reset.
- FETCH: `imem_req` = 1. On `imem_ready` = 1: latch `instr` ← `imem_rdata` and `instr_pc` ← PC, set `instr_valid`, → HOLD. Otherwise stay; the address is held stable.
- HOLD: `imem_req` = 0; `instr_valid` = 1. If `stall` = 0, the instruction is consumed at this edge: PC ← PC + 4, `instr_valid` ← 0, → FETCH. If `stall` = 1, stay and hold all outputs.
- Redirect, evaluated in FETCH and HOLD; ignored in START and during reset:
  - `jump` = 1 gives target = {`jump_target`[AW-1:2], 2'b00}.
  - Otherwise, `branch_taken` = 1 gives target = `branch_base` + 4 + (`branch_offset` << 2), computed modulo 2^ADDR_WIDTH with bits [1:0] forced to 0.
  - `jump` has priority over `branch_taken`.
- On a redirect: PC ← target, `instr_valid` ← 0, → FETCH. A redirect overrides both `stall` and `imem_ready`: any response that arrives in the same cycle is discarded and not presented. The memory side must tolerate a withdrawn request with a changed address.
- PC + 4 wraps modulo 2^ADDR_WIDTH: from the maximum word address it returns to 0, with no flag.

## Timing
- Best-case throughput: 1 instruction per 2 cycles (FETCH with ready, then HOLD without stall).
- Fetch latency: `instr_valid` rises on the edge that samples `imem_req && imem_ready`.
- The first `imem_req` is asserted 1 cycle after `reset_n` is released (START → FETCH).
- Redirect latency: `imem_addr` = target in the cycle after `branch_taken`/`jump` is sampled high. `instr_valid` is 0 in that cycle.
- All outputs are registered or decoded from state and PC only. There is no combinational path from any input to any output.
- Reset asserted mid-fetch or mid-hold returns every output to its reset value immediately (asynchronously).

## Test plan
- Reset and sequential fetch: `RESET_PC` = 0x0, memory always ready, `stall` = 0. Required: `imem_addr` sequence 0x0, 0x4, 0x8. `instr_valid` pulses every 2nd cycle with `instr_pc` = 0x0, 0x4, 0x8.
- Wait-state and stall: `imem_ready` low for 3 cycles, then high. Required: `imem_addr` is held at 0x4 throughout. Then with `stall` = 1 for 4 cycles, `instr`/`instr_pc` are held and no new `imem_req` is issued.
- Taken branch: in HOLD, drive `branch_taken` = 1, `branch_base` = 0x10, `branch_offset` = 0xFFFFFFFE. Required: next `imem_addr` = 0x0C, and the held instruction is dropped.
- Jump priority and alignment: `jump` = 1 with `jump_target` = 0x103, plus `branch_taken` = 1, in the same FETCH cycle as `imem_ready` = 1. Required: `imem_addr` = 0x100, `instr_valid` stays 0, and the returned data is discarded.
- Wrap-around: `RESET_PC` = 0xFFFFFFFC. Required: after one consumed instruction, `imem_addr` = 0x0.
- Async reset mid-operation: drop `reset_n` in HOLD between clock edges. Required: `instr_valid` = 0, `imem_req` = 0 and `instr_pc` = `RESET_PC` before the next edge. After release, `imem_req` rises one cycle later.

Source files
------------

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch stage.
// Holds the PC, fetches from instruction memory over a req/ready handshake,
// and presents each fetched instruction with its PC to decode. Branch and
// jump requests redirect the PC and drop any instruction in flight.
module pc_fetch #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INSTR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   branch_taken,
  input  logic [ADDR_WIDTH-1:0]  branch_base,
  input  logic [ADDR_WIDTH-1:0]  branch_offset,
  input  logic                   jump,
  input  logic [ADDR_WIDTH-1:0]  jump_target,
  input  logic                   stall,
  output logic                   imem_req,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  input  logic                   imem_ready,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   instr_valid,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0]  instr_pc
);

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] C_WORD       = ADDR_WIDTH'(4);
  localparam logic [ADDR_WIDTH-1:0] C_ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_t                   r_state;
  state_t                   w_next_state;
  logic [ADDR_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0]   r_instr;
  logic [ADDR_WIDTH-1:0]    r_instr_pc;

  logic                     w_redirect;
  logic                     w_capture;
  logic                     w_consume;
  logic [ADDR_WIDTH-1:0]    w_branch_sum;
  logic [ADDR_WIDTH-1:0]    w_target_raw;
  logic [ADDR_WIDTH-1:0]    w_target;

  // Redirects only count once the fetcher is running; jump beats branch.
  // Offset is in words, so shift before adding; sums wrap naturally.
  assign w_redirect   = (r_state != S_START) && (jump || branch_taken);
  assign w_branch_sum = branch_base + C_WORD + (branch_offset << 2);
  assign w_target_raw = jump ? jump_target : w_branch_sum;
  assign w_target     = w_target_raw & C_ALIGN_MASK;

  // A response that coincides with a redirect is discarded.
  assign w_capture = (r_state == S_FETCH) && imem_ready && !w_redirect;
  assign w_consume = (r_state == S_HOLD) && !stall && !w_redirect;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_START;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state selection: START runs once after reset, then FETCH/HOLD alternate.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_START: w_next_state = S_FETCH;
      S_FETCH: begin
        if (w_redirect)      w_next_state = S_FETCH;
        else if (imem_ready) w_next_state = S_HOLD;
        else                 w_next_state = S_FETCH;
      end
      S_HOLD: begin
        if (w_redirect || !stall) w_next_state = S_FETCH;
        else                      w_next_state = S_HOLD;
      end
      default: w_next_state = S_START;
    endcase
  end

  // Outputs are decoded from state and PC only, so no input reaches an output combinationally.
  always_comb begin
    imem_req    = (r_state == S_FETCH);
    instr_valid = (r_state == S_HOLD);
    imem_addr   = r_pc;
    instr       = r_instr;
    instr_pc    = r_instr_pc;
  end

  // Program counter: redirect target, or next word once the held instruction is consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc <= RESET_PC;
    end else if (w_redirect) begin
      r_pc <= w_target;
    end else if (w_consume) begin
      r_pc <= r_pc + C_WORD;
    end
  end

  // Presented instruction and its address, captured on an accepted fetch.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_instr    <= '0;
      r_instr_pc <= RESET_PC;
    end else if (w_capture) begin
      r_instr    <= imem_rdata;
      r_instr_pc <= r_pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Testbench for pc_fetch: directed scenarios plus a randomized run
// against a flag-based behavioural model.
module tb_pc_fetch;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_base = '0;
  logic [31:0] branch_offset = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        stall = 1'b0;
  logic        imem_ready = 1'b0;

  logic        req0, valid0, req1, valid1;
  logic [31:0] addr0, rdata0, instr0, ipc0;
  logic [31:0] addr1, rdata1, instr1, ipc1;

  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
  endfunction

  assign rdata0 = mem(addr0);
  assign rdata1 = mem(addr1);

  always #5 clock = ~clock;

  pc_fetch #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'h0000_0000)) u0 (
    .clock(clock), .reset_n(reset_n), .branch_taken(branch_taken),
    .branch_base(branch_base), .branch_offset(branch_offset), .jump(jump),
    .jump_target(jump_target), .stall(stall), .imem_req(req0), .imem_addr(addr0),
    .imem_ready(imem_ready), .imem_rdata(rdata0), .instr_valid(valid0),
    .instr(instr0), .instr_pc(ipc0));

  pc_fetch #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) u1 (
    .clock(clock), .reset_n(reset_n), .branch_taken(branch_taken),
    .branch_base(branch_base), .branch_offset(branch_offset), .jump(jump),
    .jump_target(jump_target), .stall(stall), .imem_req(req1), .imem_addr(addr1),
    .imem_ready(imem_ready), .imem_rdata(rdata1), .instr_valid(valid1),
    .instr(instr1), .instr_pc(ipc1));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Leaves both DUTs in START with all request inputs cleared.
  task automatic do_reset();
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    branch_base = '0; branch_offset = '0; jump_target = '0;
    reset_n = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    imem_ready = 1'b1;
    tick();
    checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL rst_req got=%0h want=0", req0); end
    checks++; if (valid0 !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0h want=0", valid0); end
    checks++; if (instr0 !== 32'h0) begin errors++; $display("FAIL rst_instr got=%h want=00000000", instr0); end
    checks++; if (addr0 !== 32'h0) begin errors++; $display("FAIL rst_addr got=%h want=00000000", addr0); end
    checks++; if (ipc1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_ipc1 got=%h want=fffffffc", ipc1); end
    checks++; if (addr1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_addr1 got=%h want=fffffffc", addr1); end
    reset_n = 1'b1;
    imem_ready = 1'b0;
    checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL start_req got=%0h want=0", req0); end
    tick();
    checks++; if (req0 !== 1'b1) begin errors++; $display("FAIL first_req got=%0h want=1", req0); end
  endtask

  task automatic test_sequential();
    do_reset();
    imem_ready = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      checks++; if (addr0 !== 32'(4 * k)) begin errors++; $display("FAIL seq_addr got=%h want=%h", addr0, 32'(4 * k)); end
      checks++; if (valid0 !== 1'b0 || req0 !== 1'b1) begin errors++; $display("FAIL seq_fetch got=v%0h/r%0h want=v0/r1", valid0, req0); end
      tick();
      checks++; if (valid0 !== 1'b1 || req0 !== 1'b0) begin errors++; $display("FAIL seq_hold got=v%0h/r%0h want=v1/r0", valid0, req0); end
      checks++; if (ipc0 !== 32'(4 * k)) begin errors++; $display("FAIL seq_ipc got=%h want=%h", ipc0, 32'(4 * k)); end
      checks++; if (instr0 !== mem(32'(4 * k))) begin errors++; $display("FAIL seq_instr got=%h want=%h", instr0, mem(32'(4 * k))); end
      tick();
    end
  endtask

  task automatic test_wait_stall();
    do_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    tick();
    imem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (addr0 !== 32'h4 || req0 !== 1'b1 || valid0 !== 1'b0) begin
        errors++; $display("FAIL wait_hold got=%h/r%0h/v%0h want=00000004/r1/v0", addr0, req0, valid0); end
      tick();
    end
    imem_ready = 1'b1;
    stall = 1'b1;
    tick();
    imem_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++; if (valid0 !== 1'b1 || req0 !== 1'b0) begin errors++; $display("FAIL stall_ctl got=v%0h/r%0h want=v1/r0", valid0, req0); end
      checks++; if (ipc0 !== 32'h4 || instr0 !== mem(32'h4)) begin
        errors++; $display("FAIL stall_data got=%h/%h want=00000004/%h", ipc0, instr0, mem(32'h4)); end
      tick();
    end
    stall = 1'b0;
    tick();
    checks++; if (addr0 !== 32'h8 || valid0 !== 1'b0) begin errors++; $display("FAIL stall_release got=%h/v%0h want=00000008/v0", addr0, valid0); end
  endtask

  task automatic test_branch();
    do_reset();
    imem_ready = 1'b1;
    tick();
    tick();
    imem_ready = 1'b0;
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_base = 32'h10;
    branch_offset = 32'hFFFF_FFFE;
    tick();
    branch_taken = 1'b0;
    checks++; if (addr0 !== 32'h0C) begin errors++; $display("FAIL br_addr got=%h want=0000000c", addr0); end
    checks++; if (valid0 !== 1'b0 || req0 !== 1'b1) begin errors++; $display("FAIL br_drop got=v%0h/r%0h want=v0/r1", valid0, req0); end
    stall = 1'b0;
  endtask

  task automatic test_jump();
    do_reset();
    tick();
    imem_ready = 1'b1;
    jump = 1'b1;
    jump_target = 32'h103;
    branch_taken = 1'b1;
    branch_base = 32'h40;
    branch_offset = 32'h8;
    tick();
    jump = 1'b0;
    branch_taken = 1'b0;
    imem_ready = 1'b0;
    checks++; if (addr0 !== 32'h100) begin errors++; $display("FAIL jmp_addr got=%h want=00000100", addr0); end
    checks++; if (valid0 !== 1'b0 || req0 !== 1'b1) begin errors++; $display("FAIL jmp_discard got=v%0h/r%0h want=v0/r1", valid0, req0); end
    tick();
    checks++; if (valid0 !== 1'b0 || addr0 !== 32'h100) begin errors++; $display("FAIL jmp_after got=v%0h/%h want=v0/00000100", valid0, addr0); end
  endtask

  task automatic test_wrap();
    do_reset();
    imem_ready = 1'b1;
    tick();
    checks++; if (addr1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first got=%h want=fffffffc", addr1); end
    tick();
    checks++; if (ipc1 !== 32'hFFFF_FFFC || valid1 !== 1'b1) begin errors++; $display("FAIL wrap_hold got=%h/v%0h want=fffffffc/v1", ipc1, valid1); end
    tick();
    checks++; if (addr1 !== 32'h0 || req1 !== 1'b1) begin errors++; $display("FAIL wrap_addr got=%h/r%0h want=00000000/r1", addr1, req1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_ready = 1'b1;
    tick();
    stall = 1'b1;
    tick();
    checks++; if (valid0 !== 1'b1 || ipc0 !== 32'h0) begin errors++; $display("FAIL ar_prehold got=v%0h/%h want=v1/00000000", valid0, ipc0); end
    tick();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (valid0 !== 1'b0 || req0 !== 1'b0) begin errors++; $display("FAIL ar_ctl got=v%0h/r%0h want=v0/r0", valid0, req0); end
    checks++; if (ipc0 !== 32'h0 || ipc1 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL ar_ipc got=%h/%h want=00000000/fffffffc", ipc0, ipc1); end
    stall = 1'b0;
    tick();
    reset_n = 1'b1;
    checks++; if (req0 !== 1'b0) begin errors++; $display("FAIL ar_start got=r%0h want=r0", req0); end
    tick();
    checks++; if (req0 !== 1'b1 || addr0 !== 32'h0) begin errors++; $display("FAIL ar_restart got=r%0h/%h want=r1/00000000", req0, addr0); end
  endtask

  // Behavioural model: "started" and "holding" flags with plain PC arithmetic.
  task automatic test_random();
    logic        m_started, m_holding;
    logic [31:0] m_pc, m_instr, m_ipc, tgt;
    logic        s_bt, s_j, s_st, s_rdy;
    logic [31:0] s_base, s_off, s_jt;
    do_reset();
    m_started = 1'b0; m_holding = 1'b0; m_pc = 32'h0; m_instr = 32'h0; m_ipc = 32'h0;
    for (int c = 0; c < 400; c++) begin
      s_rdy = ($urandom_range(0, 9) < 7);
      s_st  = ($urandom_range(0, 9) < 3);
      s_bt  = ($urandom_range(0, 9) == 0);
      s_j   = ($urandom_range(0, 19) == 0);
      s_base = $urandom;
      s_off  = (c % 2 == 0) ? 32'($signed($urandom_range(0, 63)) - 32) : $urandom;
      s_jt   = $urandom;
      imem_ready = s_rdy; stall = s_st; branch_taken = s_bt; jump = s_j;
      branch_base = s_base; branch_offset = s_off; jump_target = s_jt;
      tick();
      if (!m_started) begin
        m_started = 1'b1;
      end else if (s_j || s_bt) begin
        tgt = s_j ? s_jt : (s_base + 32'd4 + s_off * 32'd4);
        m_pc = {tgt[31:2], 2'b00};
        m_holding = 1'b0;
      end else if (m_holding) begin
        if (!s_st) begin
          m_pc = m_pc + 32'd4;
          m_holding = 1'b0;
        end
      end else if (s_rdy) begin
        m_instr = mem(m_pc);
        m_ipc = m_pc;
        m_holding = 1'b1;
      end
      checks++; if (addr0 !== m_pc) begin errors++; $display("FAIL rnd_addr cyc=%0d got=%h want=%h", c, addr0, m_pc); end
      checks++; if (req0 !== (m_started && !m_holding) || valid0 !== m_holding) begin
        errors++; $display("FAIL rnd_ctl cyc=%0d got=r%0h/v%0h want=r%0h/v%0h", c, req0, valid0, m_started && !m_holding, m_holding); end
      if (m_holding) begin
        checks++; if (instr0 !== m_instr || ipc0 !== m_ipc) begin
          errors++; $display("FAIL rnd_data cyc=%0d got=%h@%h want=%h@%h", c, instr0, ipc0, m_instr, m_ipc); end
      end
    end
    branch_taken = 1'b0; jump = 1'b0; stall = 1'b0; imem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_wait_stall();
    test_branch();
    test_jump();
    test_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
